tank_mode_sequencer: RTL and testbench

TANK_MODE_SEQUENCER -- requirements
Module: tank_mode_sequencer

---
 rtl/tank_pkg.sv | 47 ++++
 rtl/tank_sensor_bank.sv | 71 +++++++
 rtl/tank_mode_sequencer.sv | 121 ++++++++++++
 tb/tb_tank_mode_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// Shared encodings and default thresholds for the aquarium mode sequencer.
// State values double as the display-mux select codes.
package tank_pkg;

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00000,
        ST_FISH  = 5'b00001,
        ST_CLEAN = 5'b00010,
        ST_TEMP  = 5'b00100,
        ST_FOOD  = 5'b01000,
        ST_SALT  = 5'b10000,
        ST_ERROR = 5'b11111
    } state_e;

    typedef enum logic [1:0] {
        SID_CLEAN = 2'd0,
        SID_TEMP  = 2'd1,
        SID_FOOD  = 2'd2,
        SID_SALT  = 2'd3
    } sensor_id_e;

    localparam logic [15:0] DEF_DWELL     = 16'd100;
    localparam logic [7:0]  DEF_TEMP_MIN  = 8'd20;
    localparam logic [7:0]  DEF_TEMP_MAX  = 8'd30;
    localparam logic [7:0]  DEF_CLEAN_MIN = 8'd10;
    localparam logic [7:0]  DEF_FOOD_MIN  = 8'd5;
    localparam logic [7:0]  DEF_SALT_MAX  = 8'd200;
    localparam logic [7:0]  DEF_FISH_MAX  = 8'd50;

    // Bit positions within error_cause: {fish, salt, food, clean, temp}
    localparam int unsigned CAUSE_TEMP  = 0;
    localparam int unsigned CAUSE_CLEAN = 1;
    localparam int unsigned CAUSE_FOOD  = 2;
    localparam int unsigned CAUSE_SALT  = 3;
    localparam int unsigned CAUSE_FISH  = 4;

    function automatic state_e next_display(input state_e s);
        unique case (s)
            ST_FISH:  return ST_CLEAN;
            ST_CLEAN: return ST_TEMP;
            ST_TEMP:  return ST_FOOD;
            ST_FOOD:  return ST_SALT;
            default:  return ST_FISH;
        endcase
    endfunction

endpackage

// File: rtl/tank_sensor_bank.sv
// Held sensor samples plus saturating fish counter; updates in every FSM state.
module tank_sensor_bank
    import tank_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       sample_valid_i,
    input  logic [1:0] sensor_id_i,
    input  logic [7:0] sensor_data_i,
    input  logic       fish_add_i,
    input  logic       fish_remove_i,
    output logic [7:0] fish_count_o,
    output logic [7:0] cleanliness_o,
    output logic [7:0] temperature_o,
    output logic [7:0] food_storage_o,
    output logic [7:0] saltiness_o
);

    logic [7:0] fish_q, fish_d;
    logic [7:0] clean_q, clean_d;
    logic [7:0] temp_q, temp_d;
    logic [7:0] food_q, food_d;
    logic [7:0] salt_q, salt_d;

    always_comb begin
        clean_d = clean_q;
        temp_d  = temp_q;
        food_d  = food_q;
        salt_d  = salt_q;
        if (sample_valid_i) begin
            unique case (sensor_id_i)
                SID_CLEAN: clean_d = sensor_data_i;
                SID_TEMP:  temp_d  = sensor_data_i;
                SID_FOOD:  food_d  = sensor_data_i;
                default:   salt_d  = sensor_data_i;
            endcase
        end
    end

    always_comb begin
        fish_d = fish_q;
        if (fish_add_i && !fish_remove_i && fish_q != 8'hFF) begin
            fish_d = fish_q + 8'd1;
        end else if (fish_remove_i && !fish_add_i && fish_q != 8'h00) begin
            fish_d = fish_q - 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fish_q  <= '0;
            clean_q <= '0;
            temp_q  <= '0;
            food_q  <= '0;
            salt_q  <= '0;
        end else begin
            fish_q  <= fish_d;
            clean_q <= clean_d;
            temp_q  <= temp_d;
            food_q  <= food_d;
            salt_q  <= salt_d;
        end
    end

    assign fish_count_o   = fish_q;
    assign cleanliness_o  = clean_q;
    assign temperature_o  = temp_q;
    assign food_storage_o = food_q;
    assign saltiness_o    = salt_q;

endmodule

// File: rtl/tank_mode_sequencer.sv
// Display-mode sequencer: cycles sensor views on a dwell timer or advance pulse,
// and traps into ERROR while any held value breaks its alarm threshold.
module tank_mode_sequencer
    import tank_pkg::*;
#(
    parameter logic [15:0] DWELL     = DEF_DWELL,
    parameter logic [7:0]  TEMP_MIN  = DEF_TEMP_MIN,
    parameter logic [7:0]  TEMP_MAX  = DEF_TEMP_MAX,
    parameter logic [7:0]  CLEAN_MIN = DEF_CLEAN_MIN,
    parameter logic [7:0]  FOOD_MIN  = DEF_FOOD_MIN,
    parameter logic [7:0]  SALT_MAX  = DEF_SALT_MAX,
    parameter logic [7:0]  FISH_MAX  = DEF_FISH_MAX
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       run,
    input  logic       advance,
    input  logic       sample_valid,
    input  logic [1:0] sensor_id,
    input  logic [7:0] sensor_data,
    input  logic       fish_add,
    input  logic       fish_remove,
    input  logic       clear_error,
    output logic [4:0] select,
    output logic [7:0] fish_count,
    output logic [7:0] cleanliness,
    output logic [7:0] temperature,
    output logic [7:0] food_storage,
    output logic [7:0] saltiness,
    output logic       error_flag,
    output logic [4:0] error_cause
);

    state_e      state_q, state_d;
    logic [15:0] dwell_q, dwell_d;
    logic [4:0]  cause_q, cause_d;
    logic        armed_q, armed_d;
    logic [4:0]  viol;
    logic        viol_act;

    tank_sensor_bank u_bank (
        .clk_i          (CLK),
        .rst_ni         (reset),
        .sample_valid_i (sample_valid),
        .sensor_id_i    (sensor_id),
        .sensor_data_i  (sensor_data),
        .fish_add_i     (fish_add),
        .fish_remove_i  (fish_remove),
        .fish_count_o   (fish_count),
        .cleanliness_o  (cleanliness),
        .temperature_o  (temperature),
        .food_storage_o (food_storage),
        .saltiness_o    (saltiness)
    );

    always_comb begin
        viol              = '0;
        viol[CAUSE_TEMP]  = (temperature < TEMP_MIN) || (temperature > TEMP_MAX);
        viol[CAUSE_CLEAN] = cleanliness < CLEAN_MIN;
        viol[CAUSE_FOOD]  = food_storage < FOOD_MIN;
        viol[CAUSE_SALT]  = saltiness > SALT_MAX;
        viol[CAUSE_FISH]  = fish_count >= FISH_MAX;
    end

    // Alarms stay masked after reset until run is first seen, so zeroed sensors don't trip ERROR.
    always_comb begin
        state_d  = state_q;
        dwell_d  = '0;
        cause_d  = cause_q;
        armed_d  = armed_q | run;
        viol_act = armed_q && (viol != '0);
        unique case (state_q)
            ST_IDLE: begin
                if (viol_act) begin
                    state_d = ST_ERROR;
                    cause_d = viol;
                end else if (run) begin
                    state_d = ST_FISH;
                end
            end
            ST_ERROR: begin
                cause_d = cause_q | viol;
                if (clear_error && viol == '0) begin
                    state_d = ST_FISH;
                    cause_d = '0;
                end
            end
            default: begin
                if (viol_act) begin
                    state_d = ST_ERROR;
                    cause_d = viol;
                end else if (!run) begin
                    state_d = ST_IDLE;
                end else if (advance || dwell_q == DWELL - 16'd1) begin
                    state_d = next_display(state_q);
                end else begin
                    dwell_d = dwell_q + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            dwell_q <= '0;
            cause_q <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            cause_q <= cause_d;
            armed_q <= armed_d;
        end
    end

    assign select      = state_q;
    assign error_flag  = (state_q == ST_ERROR);
    assign error_cause = cause_q;

endmodule

// File: tb/tb_tank_mode_sequencer.sv
// Directed bench for tank_mode_sequencer with a short dwell of 4 cycles.
module tb_tank_mode_sequencer;

    logic       CLK;
    logic       reset;
    logic       run;
    logic       advance;
    logic       sample_valid;
    logic [1:0] sensor_id;
    logic [7:0] sensor_data;
    logic       fish_add;
    logic       fish_remove;
    logic       clear_error;
    logic [4:0] select;
    logic [7:0] fish_count;
    logic [7:0] cleanliness;
    logic [7:0] temperature;
    logic [7:0] food_storage;
    logic [7:0] saltiness;
    logic       error_flag;
    logic [4:0] error_cause;

    int unsigned n_cmp;
    int unsigned n_err;

    tank_mode_sequencer #(.DWELL(16'd4)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .run          (run),
        .advance      (advance),
        .sample_valid (sample_valid),
        .sensor_id    (sensor_id),
        .sensor_data  (sensor_data),
        .fish_add     (fish_add),
        .fish_remove  (fish_remove),
        .clear_error  (clear_error),
        .select       (select),
        .fish_count   (fish_count),
        .cleanliness  (cleanliness),
        .temperature  (temperature),
        .food_storage (food_storage),
        .saltiness    (saltiness),
        .error_flag   (error_flag),
        .error_cause  (error_cause)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input logic [1:0] id, input logic [7:0] d);
        sample_valid = 1'b1;
        sensor_id    = id;
        sensor_data  = d;
        tick(1);
        sample_valid = 1'b0;
    endtask

    logic [4:0] seq [0:4];

    initial begin
        n_cmp = 0;
        n_err = 0;
        seq[0] = 5'b00001; seq[1] = 5'b00010; seq[2] = 5'b00100;
        seq[3] = 5'b01000; seq[4] = 5'b10000;
        reset = 1'b0; run = 1'b0; advance = 1'b0; sample_valid = 1'b0;
        sensor_id = 2'd0; sensor_data = 8'd0; fish_add = 1'b0;
        fish_remove = 1'b0; clear_error = 1'b0;

        tick(2);
        chk("rst_select", select, 5'b00000);
        chk("rst_fish", fish_count, 8'h00);
        chk("rst_temp", temperature, 8'h00);
        chk("rst_err_flag", error_flag, 1'b0);
        chk("rst_cause", error_cause, 5'b00000);
        reset = 1'b1;
        tick(3);
        chk("idle_unarmed", select, 5'b00000);

        sample(2'd0, 8'd50);
        chk("load_clean", cleanliness, 8'd50);
        sample(2'd1, 8'd25);
        chk("load_temp", temperature, 8'd25);
        sample(2'd2, 8'd20);
        chk("load_food", food_storage, 8'd20);
        sample(2'd3, 8'd100);
        chk("load_salt", saltiness, 8'd100);
        chk("idle_before_run", select, 5'b00000);

        // Mode rotation every 4 cycles
        run = 1'b1;
        tick(1);
        for (int k = 0; k < 5; k++) begin
            chk("rot_entry", select, seq[k]);
            tick(3);
            chk("rot_hold", select, seq[k]);
            tick(1);
        end
        chk("rot_wrap", select, 5'b00001);

        // Advance on the dwell-expiry cycle: exactly one step
        tick(8);
        chk("at_temp", select, 5'b00100);
        tick(3);
        advance = 1'b1;
        tick(1);
        advance = 1'b0;
        chk("adv_food", select, 5'b01000);
        tick(3);
        chk("adv_dwell_restart", select, 5'b01000);
        tick(1);
        chk("adv_salt", select, 5'b10000);

        // Temperature alarm and clear behaviour
        sample(2'd1, 8'd35);
        chk("temp35_loaded", temperature, 8'd35);
        chk("temp_not_yet_err", select, 5'b10000);
        tick(1);
        chk("temp_err_sel", select, 5'b11111);
        chk("temp_err_flag", error_flag, 1'b1);
        chk("temp_err_cause", error_cause, 5'b00001);
        clear_error = 1'b1;
        tick(1);
        clear_error = 1'b0;
        chk("clear_blocked", select, 5'b11111);
        sample(2'd1, 8'd25);
        chk("temp_cause_held", error_cause, 5'b00001);
        clear_error = 1'b1;
        tick(1);
        clear_error = 1'b0;
        chk("clear_to_fish", select, 5'b00001);
        chk("clear_cause", error_cause, 5'b00000);
        chk("clear_flag", error_flag, 1'b0);

        // Fish counter alarm, floor saturation, simultaneous add/remove
        fish_add = 1'b1;
        tick(49);
        chk("fish49", fish_count, 8'd49);
        chk("fish49_no_err", error_flag, 1'b0);
        tick(1);
        fish_add = 1'b0;
        chk("fish50", fish_count, 8'd50);
        tick(1);
        chk("fish_err_sel", select, 5'b11111);
        chk("fish_err_cause", error_cause, 5'b10000);
        fish_remove = 1'b1;
        tick(1);
        chk("fish_dec_in_err", fish_count, 8'd49);
        tick(49);
        chk("fish_zero", fish_count, 8'd0);
        tick(1);
        chk("fish_floor", fish_count, 8'd0);
        fish_remove = 1'b0;
        fish_add = 1'b1;
        tick(1);
        chk("fish_one", fish_count, 8'd1);
        fish_remove = 1'b1;
        tick(2);
        fish_add = 1'b0;
        fish_remove = 1'b0;
        chk("fish_both", fish_count, 8'd1);
        chk("fish_cause_kept", error_cause, 5'b10000);
        clear_error = 1'b1;
        tick(1);
        clear_error = 1'b0;
        chk("fish_clear", select, 5'b00001);

        // Async reset mid-SALT with a salt violation pending
        advance = 1'b1;
        tick(4);
        advance = 1'b0;
        chk("reach_salt", select, 5'b10000);
        sample(2'd3, 8'd250);
        chk("salt250", saltiness, 8'd250);
        #2 reset = 1'b0;
        #1;
        chk("async_sel", select, 5'b00000);
        chk("async_salt", saltiness, 8'h00);
        chk("async_clean", cleanliness, 8'h00);
        chk("async_fish", fish_count, 8'h00);
        chk("async_flag", error_flag, 1'b0);
        chk("async_cause", error_cause, 5'b00000);
        run = 1'b0;
        #2 reset = 1'b1;
        tick(2);
        chk("post_rst_idle", select, 5'b00000);
        chk("post_rst_no_err", error_flag, 1'b0);
        run = 1'b1;
        tick(1);
        chk("post_rst_fish", select, 5'b00001);
        tick(1);
        chk("armed_err_sel", select, 5'b11111);
        chk("armed_err_cause", error_cause, 5'b00111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
